// File: rtl/arbitro_multiplicador_pkg.sv
// Shared definitions for the round-robin fixed-point multiplier: FSM encoding
// and the default Q-format (sign/integer/fraction split of a 16-bit word).
package arbitro_multiplicador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_SIGNO     = 1;
  localparam int DEF_MAGNITUD  = 3;
  localparam int DEF_PRESICION = 12;
  localparam int DEF_N_REQ     = 4;

endpackage

// File: rtl/arbitro_multiplicador_mult_q_sat.sv
// Picks the Q-format result field out of a full-width signed product and
// clamps it to the representable range when the integer part overflows.
module mult_q_sat
  import arbitro_multiplicador_pkg::*;
#(
  parameter int Width     = DEF_WIDTH,
  parameter int Signo     = DEF_SIGNO,
  parameter int Magnitud  = DEF_MAGNITUD,
  parameter int Presicion = DEF_PRESICION
) (
  input  logic signed [2*Width-1:0] i_prod,
  output logic signed [Width-1:0]   o_y,
  output logic                      o_ovf
);

  localparam int PW = 2 * Width;
  localparam int HB = PW - 1 - Signo - Magnitud;

  logic [Signo+Magnitud:0] w_top;
  logic                    w_fits;
  logic                    w_unused_lsb;

  // The result fits only if every bit above the kept field copies its sign.
  assign w_top        = i_prod[PW-1:HB];
  assign w_fits       = (&w_top) | (~|w_top);
  assign w_unused_lsb = ^i_prod[Presicion-1:0];

  always_comb begin
    o_y   = i_prod[HB:Presicion];
    o_ovf = 1'b0;
    if (!w_fits) begin
      o_ovf = 1'b1;
      o_y   = i_prod[PW-1] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    end
  end

endmodule

// File: rtl/arbitro_multiplicador.sv
// Round-robin arbiter in front of one shared saturating Q-format multiplier;
// each accepted request takes IDLE -> MUL -> OUT, one result every 3 cycles.
module arbitro_multiplicador
  import arbitro_multiplicador_pkg::*;
#(
  parameter int Width     = DEF_WIDTH,
  parameter int Signo     = DEF_SIGNO,
  parameter int Magnitud  = DEF_MAGNITUD,
  parameter int Presicion = DEF_PRESICION,
  parameter int N_REQ     = DEF_N_REQ
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic signed [N_REQ*Width-1:0] A_in,
  input  logic signed [N_REQ*Width-1:0] B_in,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          done,
  output logic signed [Width-1:0]   Y,
  output logic                      ovf,
  output logic                      busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  generate
    if (Signo + Magnitud + Presicion != Width) begin : g_bad_fmt
      $error("arbitro_multiplicador: Signo+Magnitud+Presicion must equal Width");
    end
  endgenerate

  state_t                   r_state, w_state_nxt;
  logic [IW-1:0]            r_ptr, r_idx, w_win;
  logic                     w_any;
  logic [N_REQ-1:0]         w_ack, r_done;
  logic signed [Width-1:0]  r_a, r_b, r_y;
  logic                     r_ovf;
  logic signed [2*Width-1:0] w_a_ext, w_b_ext, w_prod;
  logic signed [Width-1:0]  w_y_sat;
  logic                     w_ovf_sat;

  // Scan from the pointer; iterating downward lets the nearest hit win.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(r_ptr) + k) % N_REQ]) begin
        w_win = IW'((int'(r_ptr) + k) % N_REQ);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !reset) begin
          w_ack       = N_REQ'(1) << w_win;
          w_state_nxt = ST_MUL;
        end
      end
      ST_MUL:  w_state_nxt = ST_OUT;
      ST_OUT:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_a_ext = {{Width{r_a[Width-1]}}, r_a};
  assign w_b_ext = {{Width{r_b[Width-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  mult_q_sat #(
    .Width    (Width),
    .Signo    (Signo),
    .Magnitud (Magnitud),
    .Presicion(Presicion)
  ) u_sat (
    .i_prod(w_prod),
    .o_y   (w_y_sat),
    .o_ovf (w_ovf_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= '0;
      if (r_state == ST_IDLE && w_any) begin
        r_idx <= w_win;
        r_a   <= A_in[int'(w_win)*Width +: Width];
        r_b   <= B_in[int'(w_win)*Width +: Width];
        r_ptr <= (w_win == IW'(N_REQ - 1)) ? '0 : w_win + IW'(1);
      end
      if (r_state == ST_MUL) begin
        r_y    <= w_y_sat;
        r_ovf  <= w_ovf_sat;
        r_done <= N_REQ'(1) << r_idx;
      end
    end
  end

  assign ack  = w_ack;
  assign done = r_done;
  assign Y    = r_y;
  assign ovf  = r_ovf;
  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Directed bench for arbitro_multiplicador: arithmetic/saturation vectors,
// round-robin order, reset abort, withdrawal and back-to-back requests.
module tb_arbitro_multiplicador;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] A_in, B_in;
  logic [N-1:0] ack, done;
  logic [W-1:0] Y;
  logic         ovf, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arbitro_multiplicador #(
    .Width(16), .Signo(1), .Magnitud(3), .Presicion(12), .N_REQ(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .A_in(A_in), .B_in(B_in),
    .ack(ack), .done(done), .Y(Y), .ovf(ovf), .busy(busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req   = '0;
    A_in  = '0;
    B_in  = '0;
    step;
    step;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++; if (ack !== 4'b0)  begin errors++; $display("FAIL reset_ack got %h want 0", ack); end
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done got %h want 0", done); end
    checks++; if (Y !== 16'h0)   begin errors++; $display("FAIL reset_Y got %h want 0", Y); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_arith;
    logic [15:0] va [9] = '{16'h1800, 16'h4000, 16'h8000, 16'hC000, 16'hF000,
                            16'h7FFF, 16'h2000, 16'hFFFF, 16'h8000};
    logic [15:0] vb [9] = '{16'h2000, 16'h4000, 16'h8000, 16'h4000, 16'h2000,
                            16'h7FFF, 16'h3FFF, 16'h0001, 16'h1000};
    logic [15:0] vy [9] = '{16'h3000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hE000,
                            16'h7FFF, 16'h7FFE, 16'hFFFF, 16'h8000};
    logic        vo [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] oh;
    int idx;
    for (int i = 0; i < 9; i++) begin
      idx  = i % N;
      oh   = 4'b0001 << idx;
      A_in = '0;
      B_in = '0;
      A_in[idx*W +: W] = va[i];
      B_in[idx*W +: W] = vb[i];
      req  = oh;
      #1;
      checks++; if (ack !== oh) begin errors++; $display("FAIL arith%0d_ack got %h want %h", i, ack, oh); end
      step;
      req = '0;
      #1;
      checks++; if (busy !== 1'b1 || done !== 4'b0) begin errors++; $display("FAIL arith%0d_mul busy %b done %h want 1 0", i, busy, done); end
      step;
      #1;
      checks++; if (done !== oh) begin errors++; $display("FAIL arith%0d_done got %h want %h", i, done, oh); end
      checks++; if (Y !== vy[i]) begin errors++; $display("FAIL arith%0d_Y got %h want %h", i, Y, vy[i]); end
      checks++; if (ovf !== vo[i]) begin errors++; $display("FAIL arith%0d_ovf got %b want %b", i, ovf, vo[i]); end
      step;
      #1;
      checks++; if (done !== 4'b0 || Y !== vy[i]) begin errors++; $display("FAIL arith%0d_hold done %h Y %h want 0 %h", i, done, Y, vy[i]); end
    end
  endtask

  task automatic test_fairness;
    logic [N-1:0] exp_ack, exp_done;
    logic [15:0]  exp_y;
    do_reset;
    for (int i = 0; i < N; i++) begin
      A_in[i*W +: W] = 16'h1000;
      B_in[i*W +: W] = 16'(16'h1000 * (i + 1));
    end
    req = 4'hF;
    for (int c = 0; c < 15; c++) begin
      if (c != 0) step;
      #1;
      exp_ack  = (c % 3 == 0) ? (4'b0001 << ((c / 3) % N)) : 4'b0;
      exp_done = (c % 3 == 2) ? (4'b0001 << ((c / 3) % N)) : 4'b0;
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rr_c%0d_ack got %h want %h", c, ack, exp_ack); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL rr_c%0d_done got %h want %h", c, done, exp_done); end
      if (c % 3 == 2) begin
        exp_y = 16'(16'h1000 * (((c / 3) % N) + 1));
        checks++; if (Y !== exp_y) begin errors++; $display("FAIL rr_c%0d_Y got %h want %h", c, Y, exp_y); end
      end
    end
    req = '0;
    step;
  endtask

  task automatic test_reset_abort;
    A_in = '0;
    B_in = '0;
    A_in[0*W +: W] = 16'h1800;
    B_in[0*W +: W] = 16'h2000;
    req = 4'b0001;
    #1;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL abort_ack0 got %h want 1", ack); end
    step;
    reset = 1'b1;
    req   = '0;
    step;
    req = 4'b0100;
    A_in[2*W +: W] = 16'h1000;
    B_in[2*W +: W] = 16'h3000;
    #1;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL abort_ack_in_reset got %h want 0", ack); end
    checks++; if (done !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_state done %h busy %b want 0 0", done, busy); end
    checks++; if (Y !== 16'h0 || ovf !== 1'b0) begin errors++; $display("FAIL abort_out Y %h ovf %b want 0 0", Y, ovf); end
    step;
    reset = 1'b0;
    #1;
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL abort_no_done got %h want 0", done); end
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL abort_ack2 got %h want 4", ack); end
    step;
    req = '0;
    step;
    #1;
    checks++; if (done !== 4'b0100) begin errors++; $display("FAIL abort_done2 got %h want 4", done); end
    checks++; if (Y !== 16'h3000 || ovf !== 1'b0) begin errors++; $display("FAIL abort_Y2 Y %h ovf %b want 3000 0", Y, ovf); end
    step;
  endtask

  task automatic test_withdrawal;
    A_in = '0;
    B_in = '0;
    A_in[0*W +: W] = 16'h1000;
    B_in[0*W +: W] = 16'h1000;
    A_in[1*W +: W] = 16'h2000;
    B_in[1*W +: W] = 16'h2000;
    req = 4'b0001;
    #1;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wd_ack0 got %h want 1", ack); end
    step;
    req = 4'b0010;
    #1;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL wd_ack_mul got %h want 0", ack); end
    step;
    req = '0;
    #1;
    checks++; if (done !== 4'b0001 || Y !== 16'h1000) begin errors++; $display("FAIL wd_done0 done %h Y %h want 1 1000", done, Y); end
    for (int c = 0; c < 4; c++) begin
      step;
      #1;
      checks++; if (ack !== 4'b0 || done !== 4'b0) begin errors++; $display("FAIL wd_idle%0d ack %h done %h want 0 0", c, ack, done); end
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] exp_ack;
    A_in[0*W +: W] = 16'hF000;
    B_in[0*W +: W] = 16'hF000;
    req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) step;
      #1;
      exp_ack = (c % 3 == 0) ? 4'b0001 : 4'b0;
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL b2b_c%0d_ack got %h want %h", c, ack, exp_ack); end
      if (c % 3 == 2) begin
        checks++; if (done !== 4'b0001 || Y !== 16'h1000) begin errors++; $display("FAIL b2b_c%0d_out done %h Y %h want 1 1000", c, done, Y); end
      end
    end
    req = '0;
    step;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    A_in  = '0;
    B_in  = '0;
    test_reset;
    test_arith;
    test_fairness;
    test_reset_abort;
    test_withdrawal;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_multiplicador.md
ARBITRO_MULTIPLICADOR -- requirements
Module: arbitro_multiplicador

Interface
REQ-001 Parameter Width, default 16, operand and result word width in bits.
REQ-002 Parameter Signo, default 1, sign bits of the fixed-point format.
REQ-003 Parameter Magnitud, default 3, integer bits of the fixed-point format.
REQ-004 Parameter Presicion, default 12, fractional bits; the block SHALL require Signo+Magnitud+Presicion == Width.
REQ-005 Parameter N_REQ, default 4, number of requesters.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port req, input, N_REQ bits: req[i] high means requester i has an operation pending.
REQ-009 Port A_in, input, N_REQ*Width bits, signed: slice i is requester i's first operand.
REQ-010 Port B_in, input, N_REQ*Width bits, signed: slice i is requester i's second operand.
REQ-011 Port ack, output, N_REQ bits: one-hot one-cycle pulse; it means operands i are accepted.
REQ-012 Port done, output, N_REQ bits: one-hot one-cycle pulse; it means Y holds requester i's result.
REQ-013 Port Y, output, Width bits, signed: saturated fixed-point product.
REQ-014 Port ovf, output, 1 bit: high when the current Y was saturated.
REQ-015 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE -> MUL -> OUT -> IDLE; MUL and OUT SHALL each last exactly one cycle.
REQ-017 In IDLE with req != 0, the block SHALL combinationally assert ack[w] for the round-robin winner w in that cycle.
REQ-018 On the ack edge, the block SHALL latch A_in[w] and B_in[w] and w, and go to MUL; with req == 0 it SHALL stay in IDLE.
REQ-019 Round-robin: the search SHALL start at pointer p; after a grant to w, p SHALL become (w+1) mod N_REQ; p SHALL reset to 0.
REQ-020 In MUL, the block SHALL register the full 2*Width-bit signed product P of the latched operands.
REQ-021 At the end of MUL, the block SHALL register Y, ovf and done[w], so that they are valid during OUT; latency is ack cycle t -> done in cycle t+2.
REQ-022 Arithmetic: the nominal result SHALL be P[2*Width-1-Signo-Magnitud : Presicion], truncated toward minus infinity, with no rounding.
REQ-023 Saturation: if P[2*Width-1 : 2*Width-1-Signo-Magnitud] are not all equal, then Y SHALL be 2^(Width-1)-1 when P[2*Width-1]=0, else -2^(Width-1), and ovf SHALL be 1; otherwise ovf SHALL be 0.
REQ-024 Y and ovf SHALL hold their value until the next OUT; done SHALL be 0 outside OUT.
REQ-025 Maximum throughput SHALL be one operation per 3 cycles; the earliest next ack is in cycle t+3.
REQ-026 req changes in MUL/OUT SHALL be ignored; a req dropped before its ack SHALL never be served.
REQ-027 A requester SHALL hold req and its operands stable until ack; if req[i] is still high after ack, it SHALL be treated as a new request.

Reset
REQ-028 While reset is high at a clock edge, state SHALL go to IDLE and p=0; ack, done, Y, ovf and busy SHALL read 0 from the next cycle.
REQ-029 A reset in MUL or OUT SHALL abort the operation; no done SHALL be produced for it.
REQ-030 ack SHALL be forced to 0 during any cycle in which reset is high.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE, MUL, OUT) and the default format constants 16/1/3/12.
REQ-032 Saturation and bit-selection SHALL live in one combinational sub-module, mult_q_sat, parameterized like this block.

Verification
REQ-033 Scenario, single operation: req[0] with A=0x1800 (1.5) and B=0x2000 (2.0) -> ack[0] in cycle t; done[0], Y=0x3000 and ovf=0 in cycle t+2.
REQ-034 Scenario, positive saturation: A=0x4000 and B=0x4000 (4.0 × 4.0) -> Y=0x7FFF, ovf=1; A=0x8000 and B=0x8000 -> Y=0x7FFF, ovf=1.
REQ-035 Scenario, negative saturation and negative result: A=0xC000 and B=0x4000 -> Y=0x8000, ovf=1; A=0xF000 and B=0x2000 (-1 × 2) -> Y=0xE000, ovf=0.
REQ-036 Scenario, fairness: req=4'b1111 held after reset -> ack order 0,1,2,3,0, with acks 3 cycles apart; each done[i] follows 2 cycles after its ack[i].
REQ-037 Scenario, reset abort: reset asserted during MUL -> no done, Y=0, ovf=0, busy=0; a new req[2] is then served with its normal latency.
REQ-038 Scenario, withdrawal: req[1] pulsed during MUL of requester 0 and dropped before IDLE -> no ack[1] and no done[1].
